// File: rtl/hyper_ctrl.sv
// Hypervisor register window ($D640-$D67F): user-state register file, user-mode write trap,
// and a restore sequencer that replays R0..R(N-1) to the CPU when the hypervisor exits.
module hyper_ctrl #(
    parameter logic [5:0] EXIT_OFFSET   = 6'h3F,
    parameter int         NUM_USER_REGS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hyper_cs,
    input  logic [7:0] hyper_addr,
    input  logic [7:0] hyper_io_data_i,
    input  logic       cpu_write,
    input  logic       ready,
    input  logic       hyper_mode,
    output logic [7:0] hyper_data_o,
    output logic       hyp,
    output logic       load_user_reg,
    output logic [7:0] user_mapper_reg
);

    localparam int               IDX_W       = (NUM_USER_REGS > 1) ? $clog2(NUM_USER_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_USER_REGS - 1);
    localparam logic [6:0]       NUM_REGS_7  = 7'(NUM_USER_REGS);
    localparam logic [5:0]       TRAP_ID_OFF = 6'h10;

    typedef enum logic {
        S_IDLE,
        S_RESTORE
    } seq_state_e;

    // Sequencer state and its registered outputs
    seq_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_inc;
    logic             load_q;
    logic [7:0]       mapper_q;

    // Register window state
    logic [7:0] user_q [NUM_USER_REGS];
    logic [7:0] trap_id_q, trap_id_d;
    logic       hyp_q, hyp_d;
    logic [7:0] rd_data_q, rd_data_d;

    // Bus decode
    logic [5:0]       offset;
    logic [IDX_W-1:0] reg_sel;
    logic             is_user_off;
    logic             acc_wr;
    logic             acc_rd;
    logic             reg_wr;
    logic             exit_req;
    logic             unused_addr_hi;

    assign offset         = hyper_addr[5:0];
    assign reg_sel        = offset[IDX_W-1:0];
    assign is_user_off    = ({1'b0, offset} < NUM_REGS_7);
    assign acc_wr         = hyper_cs & ready & cpu_write;
    assign acc_rd         = hyper_cs & ready & ~cpu_write;
    assign unused_addr_hi = &{1'b0, hyper_addr[7:6]};

    // The register file is frozen while its contents are being replayed to the CPU.
    assign reg_wr   = acc_wr & hyper_mode & is_user_off & (state_q == S_IDLE);
    assign exit_req = acc_wr & hyper_mode & (offset == EXIT_OFFSET);
    assign idx_inc  = idx_q + 1'b1;

    assign hyper_data_o    = rd_data_q;
    assign hyp             = hyp_q;
    assign load_user_reg   = load_q;
    assign user_mapper_reg = mapper_q;

    always_comb begin
        rd_data_d = rd_data_q;
        if (acc_rd) begin
            if (is_user_off) begin
                rd_data_d = user_q[reg_sel];
            end else if (offset == TRAP_ID_OFF) begin
                rd_data_d = trap_id_q;
            end else begin
                rd_data_d = 8'h00;
            end
        end
    end

    // Any user-mode write traps; hyp drops on the first edge that sees hypervisor mode.
    always_comb begin
        hyp_d     = hyp_q;
        trap_id_d = trap_id_q;
        if (acc_wr && !hyper_mode) begin
            hyp_d     = 1'b1;
            trap_id_d = {2'b00, offset};
        end else if (hyper_mode) begin
            hyp_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= 8'h00;
            hyp_q     <= 1'b0;
            trap_id_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
            hyp_q     <= hyp_d;
            trap_id_q <= trap_id_d;
        end
    end

    // NOTE: the register file is reset element by element because software relies on
    // restoring all-zero user state after reset; a plain RAM without reset would not do.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_USER_REGS; i++) begin
                user_q[i] <= 8'h00;
            end
        end else if (reg_wr) begin
            user_q[reg_sel] <= hyper_io_data_i;
        end
    end

    // Restore sequencer: outputs are registered alongside the state so that
    // user_mapper_reg always presents the register addressed by the current index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            load_q   <= 1'b0;
            mapper_q <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (exit_req) begin
                        state_q  <= S_RESTORE;
                        idx_q    <= '0;
                        load_q   <= 1'b1;
                        mapper_q <= user_q[0];
                    end
                end
                S_RESTORE: begin
                    if (ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q  <= S_IDLE;
                            idx_q    <= '0;
                            load_q   <= 1'b0;
                            mapper_q <= 8'h00;
                        end else begin
                            idx_q    <= idx_inc;
                            mapper_q <= user_q[idx_inc];
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    idx_q    <= '0;
                    load_q   <= 1'b0;
                    mapper_q <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyper_ctrl.sv
// Directed and randomized bench for hyper_ctrl against a transaction-level model
// (register array, trap flag, and a queue of bytes still to be replayed).
module tb_hyper_ctrl;

    logic       clk;
    logic       reset;
    logic       hyper_cs;
    logic [7:0] hyper_addr;
    logic [7:0] hyper_io_data_i;
    logic       cpu_write;
    logic       ready;
    logic       hyper_mode;
    logic [7:0] hyper_data_o;
    logic       hyp;
    logic       load_user_reg;
    logic [7:0] user_mapper_reg;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [7:0] m_regs [16];
    logic [7:0] m_trap;
    logic [7:0] m_rd;
    logic       m_hyp;
    logic [7:0] m_q [$];

    hyper_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .hyper_cs        (hyper_cs),
        .hyper_addr      (hyper_addr),
        .hyper_io_data_i (hyper_io_data_i),
        .cpu_write       (cpu_write),
        .ready           (ready),
        .hyper_mode      (hyper_mode),
        .hyper_data_o    (hyper_data_o),
        .hyp             (hyp),
        .load_user_reg   (load_user_reg),
        .user_mapper_reg (user_mapper_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_trap = 8'h00;
        m_rd   = 8'h00;
        m_hyp  = 1'b0;
        m_q.delete();
    endtask

    // One clock cycle: drive at the falling edge, update the model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input logic rst, input logic cs, input logic [7:0] addr,
                        input logic [7:0] data, input logic wr, input logic rdy,
                        input logic hm);
        logic       busy, acc_w, acc_r;
        logic [5:0] off;
        reset           = rst;
        hyper_cs        = cs;
        hyper_addr      = addr;
        hyper_io_data_i = data;
        cpu_write       = wr;
        ready           = rdy;
        hyper_mode      = hm;
        @(posedge clk);
        off   = addr[5:0];
        busy  = (m_q.size() != 0);
        acc_w = cs & rdy & wr;
        acc_r = cs & rdy & ~wr;
        if (rst) begin
            model_reset();
        end else begin
            if (acc_r) m_rd = (off < 16) ? m_regs[off[3:0]] : (off == 6'h10) ? m_trap : 8'h00;
            if (hm) m_hyp = 1'b0;
            else if (acc_w) begin
                m_hyp  = 1'b1;
                m_trap = {2'b00, off};
            end
            if (busy && rdy) void'(m_q.pop_front());
            else if (!busy && acc_w && hm && off == 6'h3F)
                for (int i = 0; i < 16; i++) m_q.push_back(m_regs[i]);
            if (acc_w && hm && off < 16 && !busy) m_regs[off[3:0]] = data;
        end
        @(negedge clk);
        check("hyper_data_o", hyper_data_o, m_rd);
        check("hyp", {7'd0, hyp}, {7'd0, m_hyp});
        check("load_user_reg", {7'd0, load_user_reg}, (m_q.size() != 0) ? 8'd1 : 8'd0);
        check("user_mapper_reg", user_mapper_reg, (m_q.size() != 0) ? m_q[0] : 8'h00);
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data, input logic hm);
        step(1'b0, 1'b1, addr, data, 1'b1, 1'b1, hm);
    endtask

    task automatic rd_reg(input logic [7:0] addr, input logic hm);
        step(1'b0, 1'b1, addr, 8'h00, 1'b0, 1'b1, hm);
    endtask

    task automatic idle(input logic rdy, input logic hm);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, rdy, hm);
    endtask

    initial begin
        int         load_cnt;
        logic [7:0] a;
        reset = 1'b1; hyper_cs = 1'b0; hyper_addr = 8'h00; hyper_io_data_i = 8'h00;
        cpu_write = 1'b0; ready = 1'b1; hyper_mode = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // User-mode write traps, TRAP_ID latches offset, R5 untouched, hyp clears in hyper mode
        wr_reg(8'h45, 8'h12, 1'b0);
        check("trap_hyp_direct", {7'd0, hyp}, 8'd1);
        rd_reg(8'h05, 1'b0);
        check("r5_unchanged", hyper_data_o, 8'h00);
        rd_reg(8'h10, 1'b0);
        check("trap_id_05", hyper_data_o, 8'h05);
        idle(1'b1, 1'b1);
        check("hyp_cleared", {7'd0, hyp}, 8'd0);

        // Second trap while hyp high overwrites TRAP_ID
        wr_reg(8'h47, 8'h00, 1'b0);
        wr_reg(8'h4A, 8'h00, 1'b0);
        rd_reg(8'h10, 1'b0);
        idle(1'b1, 1'b1);

        // Hypervisor write/readback, TRAP_ID readback, unmapped offset reads zero
        wr_reg(8'h40, 8'hA5, 1'b1);
        rd_reg(8'h40, 1'b1);
        check("r0_readback", hyper_data_o, 8'hA5);
        rd_reg(8'h50, 1'b1);
        rd_reg(8'h20, 1'b1);
        wr_reg(8'h55, 8'h77, 1'b1);
        rd_reg(8'h50, 1'b1);

        // Access with ready low does nothing
        step(1'b0, 1'b1, 8'h41, 8'h99, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h41, 8'h99, 1'b1, 1'b0, 1'b1);
        rd_reg(8'h41, 1'b1);
        check("ready_low_nowrite", hyper_data_o, 8'h00);

        // Restore with ready toggling: 32 cycles of load_user_reg
        for (int i = 0; i < 16; i++) wr_reg(8'h40 + 8'(i), 8'h40 + 8'(i), 1'b1);
        wr_reg(8'h7F, 8'hEE, 1'b1);
        load_cnt = int'(load_user_reg);
        for (int i = 0; i < 32; i++) begin
            idle(1'(i % 2), 1'b1);
            load_cnt += int'(load_user_reg);
        end
        check("load_cycles", 8'(load_cnt), 8'd32);
        idle(1'b1, 1'b1);

        // Exit and R3 writes during restore are ignored; hyper_mode drop mid-sequence
        wr_reg(8'h7F, 8'h00, 1'b1);
        wr_reg(8'h7F, 8'h00, 1'b1);
        wr_reg(8'h43, 8'hC3, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        for (int i = 0; i < 14; i++) idle(1'b1, 1'b1);
        rd_reg(8'h43, 1'b1);
        check("r3_kept", hyper_data_o, 8'h43);

        // Reset at restore index 7
        wr_reg(8'h7F, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) idle(1'b1, 1'b1);
        check("index7_value", user_mapper_reg, 8'h47);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check("abort_load", {7'd0, load_user_reg}, 8'd0);
        for (int i = 0; i < 16; i++) rd_reg(8'h40 + 8'(i), 1'b1);
        rd_reg(8'h50, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = 8'h40 | 8'($urandom_range(0, 15));
                5:             a = 8'h50;
                6, 7:          a = 8'h7F;
                default:       a = 8'($urandom);
            endcase
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, a, 8'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyper_ctrl.md
HYPER_CTRL -- requirements
Module: hyper_ctrl

Interface
REQ-001 Parameter EXIT_OFFSET, default 6'h3F: hypervisor-window offset whose write in hypervisor mode requests exit to user mode.
REQ-002 Parameter NUM_USER_REGS, default 16: number of 8-bit user-state registers (4-bit index).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 hyper_cs  input  1  chip select; high when the CPU next-cycle address is in $D640-$D67F.
REQ-006 hyper_addr  input  8  low byte of the CPU next-cycle address; offset = hyper_addr[5:0].
REQ-007 hyper_io_data_i  input  8  CPU write data (next-cycle).
REQ-008 cpu_write  input  1  CPU next-cycle write strobe.
REQ-009 ready  input  1  bus-cycle qualifier; no access, trap or sequencer step takes effect while low.
REQ-010 hyper_mode  input  1  CPU is executing in hypervisor mode.
REQ-011 hyper_data_o  output  8  registered read data.
REQ-012 hyp  output  1  hypervisor trap request to the CPU.
REQ-013 load_user_reg  output  1  user-register restore strobe to the CPU.
REQ-014 user_mapper_reg  output  8  user-register restore data to the CPU.

Function
REQ-015 Access = hyper_cs & ready; write access = access & cpu_write; read access = access & ~cpu_write.
REQ-016 Register map: offsets 0x00-0x0F = user regs R0-R15 (0 A, 1 X, 2 Y, 3 Z, 4 B, 5 SPL, 6 SPH, 7 P, 8 PCL, 9 PCH, 10-15 mapper bytes); 0x10 = TRAP_ID (read-only); other offsets read 0x00.
REQ-017 Read: on a read access edge, hyper_data_o <= selected register value, giving 1-cycle latency; hyper_data_o holds otherwise; reads are allowed in either mode.
REQ-018 Hypervisor write (hyper_mode=1, offset 0x00-0x0F): Rn <= hyper_io_data_i on that edge.
REQ-019 Hypervisor write to other offsets except EXIT_OFFSET: ignored.
REQ-020 Trap: a write access with hyper_mode=0, any offset, sets TRAP_ID <= offset and hyp <= 1 on that edge; registers are not modified.
REQ-021 hyp stays high until an edge samples hyper_mode=1, then clears on that edge; a second user-mode write while hyp=1 overwrites TRAP_ID.
REQ-022 Exit: a write access with hyper_mode=1 and offset = EXIT_OFFSET, data ignored, starts the restore sequencer if idle; ignored if the sequencer is busy.
REQ-023 Sequencer states: IDLE, RESTORE.
REQ-024 IDLE: load_user_reg=0.
REQ-025 RESTORE: index 0 to 15; load_user_reg=1; user_mapper_reg=R[index].
REQ-026 RESTORE index increments only on edges with ready=1; after the edge at index 15 with ready=1, the sequencer returns to IDLE; it takes exactly 16 ready cycles.
REQ-027 Register writes are ignored while the sequencer is in RESTORE; the sequencer continues if hyper_mode drops mid-sequence.
REQ-028 user_mapper_reg = 0x00 in IDLE.

Reset
REQ-029 On reset: hyp=0, load_user_reg=0, user_mapper_reg=0x00, hyper_data_o=0x00, R0-R15=0x00, TRAP_ID=0x00, sequencer IDLE index 0.
REQ-030 Reset overrides every other event, including aborting an active RESTORE.

Verification
REQ-031 hyper_mode=0, write $D645 = 0x12 with ready=1 -> next cycle hyp=1, TRAP_ID=0x05, R5 unchanged; raise hyper_mode -> hyp=0 after one edge.
REQ-032 hyper_mode=1, write R0=0xA5, then read offset 0x00 -> hyper_data_o=0xA5 one cycle after the read edge; read offset 0x10 -> 0x05.
REQ-033 Write with hyper_cs=1, cpu_write=1 but ready=0 -> no register change, no hyp.
REQ-034 hyper_mode=1, R0..R15 = 0x40..0x4F, write offset 0x3F, ready toggling every cycle -> load_user_reg high for 32 cycles, user_mapper_reg steps 0x40..0x4F (each held 2 cycles), then IDLE.
REQ-035 Assert reset at RESTORE index 7 -> next edge load_user_reg=0, user_mapper_reg=0x00, all registers 0x00.
REQ-036 Second exit write during RESTORE and R3 write during RESTORE -> both ignored; sequence unchanged.
